game_timer_ctrl: RTL and testbench

//  Upstream control stage for the 3-digit BCD game-time down counter.

---
 rtl/game_timer_ctrl_if.sv | 27 ++
 rtl/game_timer_ctrl.sv | 171 +++++++++++++++++
 tb/tb_game_timer_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_timer_ctrl_if.sv
// Control-side bundle of game_timer_ctrl: game/counter inputs and the strobes it drives.
// The master drives the requests and counter status; the slave (the controller) drives the rest.
interface game_timer_ctrl_if;
    logic       start_game;
    logic       pause_req;
    logic       bonus_req;
    logic       timer_tc;
    logic [3:0] count_h;
    logic [3:0] count_m;
    logic       one_sec_en;
    logic       run_en;
    logic       load_n;
    logic       add_time_n;
    logic       time_up;
    logic [2:0] state;
    logic       low_time;

    modport master (
        output start_game, pause_req, bonus_req, timer_tc, count_h, count_m,
        input  one_sec_en, run_en, load_n, add_time_n, time_up, state, low_time
    );

    modport slave (
        input  start_game, pause_req, bonus_req, timer_tc, count_h, count_m,
        output one_sec_en, run_en, load_n, add_time_n, time_up, state, low_time
    );
endinterface

// File: rtl/game_timer_ctrl.sv
// Upstream control for the BCD game-time down counter: 1 s tick, load/bonus strobes, pause, expiry.
// Optional blinking low-time warning is built when TIMER_WARN_EN is defined.
module game_timer_ctrl #(
    parameter int unsigned TICKS_PER_SEC = 31_500_000,
    parameter int unsigned BONUS_MAX     = 3
) (
    input  logic             clk,
    input  logic             reset,
    game_timer_ctrl_if.slave bus
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned QW = (BONUS_MAX > 0) ? $clog2(BONUS_MAX + 1) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [QW-1:0] QUEUE_MAX  = QW'(BONUS_MAX);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoad    = 3'd1,
        StRun     = 3'd2,
        StPaused  = 3'd3,
        StExpired = 3'd4
    } state_e;

    state_e          r_state;
    state_e          w_next;
    logic            r_pause_q;
    logic            r_bonus_q;
    logic [PW-1:0]   r_presc;
    logic [QW-1:0]   r_queue;
    logic [QW-1:0]   w_queue_nxt;
    logic            r_one_sec_en;
    logic            r_run_en;
    logic            r_load_n;
    logic            r_add_time_n;
    logic            r_time_up;
    logic            w_pause_edge;
    logic            w_bonus_edge;
    logic            w_run_hold;
    logic            w_tick;
    logic            w_issue;
    logic            w_queue_live;

    assign w_pause_edge = bus.pause_req & ~r_pause_q;
    assign w_bonus_edge = bus.bonus_req & ~r_bonus_q;

    always_comb begin
        w_next = r_state;
        if (bus.start_game) begin
            w_next = StLoad;
        end else begin
            case (r_state)
                StIdle:    w_next = StIdle;
                StLoad:    w_next = StRun;
                StRun: begin
                    if (bus.timer_tc)  w_next = StExpired;
                    else if (w_pause_edge) w_next = StPaused;
                end
                StPaused:  if (w_pause_edge) w_next = StRun;
                StExpired: w_next = StExpired;
                default:   w_next = StIdle;
            endcase
        end
    end

    // Staying in RUN implies no restart, no expiry and no pause this cycle.
    assign w_run_hold = (r_state == StRun) && (w_next == StRun);
    assign w_tick     = w_run_hold && (r_presc == PRESC_LAST);

    // Strobe must not land on a tick cycle or the cycle right after one.
    assign w_issue = w_run_hold && (r_queue != '0) && (bus.count_m <= 4'd6) &&
                     !w_tick && !r_one_sec_en && r_add_time_n;

    assign w_queue_live = (r_state == StRun || r_state == StPaused) &&
                          (w_next == StRun || w_next == StPaused);

    always_comb begin
        w_queue_nxt = '0;
        if (w_queue_live) begin
            w_queue_nxt = r_queue;
            if (w_issue) begin
                if (!w_bonus_edge) w_queue_nxt = r_queue - QW'(1);
            end else if (w_bonus_edge && (r_queue != QUEUE_MAX)) begin
                w_queue_nxt = r_queue + QW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_pause_q    <= 1'b0;
            r_bonus_q    <= 1'b0;
            r_presc      <= '0;
            r_queue      <= '0;
            r_one_sec_en <= 1'b0;
            r_run_en     <= 1'b0;
            r_load_n     <= 1'b1;
            r_add_time_n <= 1'b1;
            r_time_up    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_pause_q    <= bus.pause_req;
            r_bonus_q    <= bus.bonus_req;
            r_queue      <= w_queue_nxt;
            r_one_sec_en <= w_tick;
            r_run_en     <= (w_next == StRun);
            r_load_n     <= (w_next != StLoad);
            r_add_time_n <= !w_issue;
            r_time_up    <= (w_next == StExpired);
            if (w_next == StLoad || w_tick) begin
                r_presc <= '0;
            end else if (w_run_hold) begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    assign bus.state      = r_state;
    assign bus.one_sec_en = r_one_sec_en;
    assign bus.run_en     = r_run_en;
    assign bus.load_n     = r_load_n;
    assign bus.add_time_n = r_add_time_n;
    assign bus.time_up    = r_time_up;

`ifdef TIMER_WARN_EN
    localparam int unsigned BLINK_CYC = (TICKS_PER_SEC >= 4) ? TICKS_PER_SEC / 4 : 1;
    localparam int unsigned BW        = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

    logic          r_low_time;
    logic          r_warn_on;
    logic [BW-1:0] r_blink_cnt;
    logic          w_warn;

    assign w_warn = (bus.count_h == 4'd0) && (bus.count_m == 4'd0);

    // Blink phase only advances while running; pause transitions freeze it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_low_time  <= 1'b0;
            r_warn_on   <= 1'b0;
            r_blink_cnt <= '0;
        end else if (w_run_hold) begin
            if (!w_warn) begin
                r_low_time  <= 1'b0;
                r_warn_on   <= 1'b0;
                r_blink_cnt <= '0;
            end else if (!r_warn_on) begin
                r_low_time  <= 1'b1;
                r_warn_on   <= 1'b1;
                r_blink_cnt <= '0;
            end else if (r_blink_cnt == BLINK_LAST) begin
                r_low_time  <= ~r_low_time;
                r_blink_cnt <= '0;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end else if (!(w_next == StRun || w_next == StPaused)) begin
            r_low_time  <= 1'b0;
            r_warn_on   <= 1'b0;
            r_blink_cnt <= '0;
        end
    end

    assign bus.low_time = r_low_time;
`else
    assign bus.low_time = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Self-checking bench for game_timer_ctrl: directed scenarios then random stimulus against a
// cycle-count/timestamp reference model of the controller rules.
module tb_game_timer_ctrl;
    localparam int unsigned T  = 8;
    localparam int unsigned BM = 3;
    localparam logic [8:0] RST_VEC = {3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef TIMER_WARN_EN
    localparam logic [8:0] VMASK = 9'h1FE;
`else
    localparam logic [8:0] VMASK = 9'h1FF;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    game_timer_ctrl_if bus ();

    game_timer_ctrl #(
        .TICKS_PER_SEC(T),
        .BONUS_MAX    (BM)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model: mode number, count of counting RUN cycles, queue depth, event timestamps.
    int         m_mode, m_active, m_q, m_cyc, m_last_tick, m_last_issue;
    logic       m_prev_p, m_prev_b;
    logic [8:0] exp_vec;
    int         n_tick, n_strobe, n_close, last_strobe_cyc, obs_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] obs_vec();
        return {bus.state, bus.one_sec_en, bus.run_en, bus.load_n, bus.add_time_n,
                bus.time_up, bus.low_time} & VMASK;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_active = 0; m_q = 0; m_cyc = 0;
        m_last_tick = -100; m_last_issue = -100;
        m_prev_p = 1'b0; m_prev_b = 1'b0;
        exp_vec = RST_VEC;
    endtask

    task automatic model_step();
        int   nxt;
        logic pe, be, counting, tk, iss;
        pe  = bus.pause_req && !m_prev_p;
        be  = bus.bonus_req && !m_prev_b;
        nxt = m_mode;
        if (bus.start_game) nxt = 1;
        else if (m_mode == 1) nxt = 2;
        else if (m_mode == 2 && bus.timer_tc) nxt = 4;
        else if ((m_mode == 2 || m_mode == 3) && pe) nxt = (m_mode == 2) ? 3 : 2;
        counting = (m_mode == 2) && (nxt == 2);
        tk = 1'b0;
        if (counting) begin
            m_active++;
            tk = (m_active % T) == 0;
        end
        if (nxt == 1) m_active = 0;
        iss = counting && (m_q > 0) && (bus.count_m <= 6) && !tk &&
              (m_last_tick != m_cyc) && (m_cyc + 1 - m_last_issue >= 2);
        if ((m_mode == 2 || m_mode == 3) && (nxt == 2 || nxt == 3)) begin
            if (iss && !be) m_q--;
            else if (!iss && be && m_q < BM) m_q++;
        end else begin
            m_q = 0;
        end
        m_cyc++;
        if (tk)  m_last_tick  = m_cyc;
        if (iss) m_last_issue = m_cyc;
        m_mode   = nxt;
        m_prev_p = bus.pause_req;
        m_prev_b = bus.bonus_req;
        exp_vec  = {3'(nxt), tk, nxt == 2, nxt != 1, !iss, nxt == 4, 1'b0};
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        obs_cyc++;
        chk("cycle", 32'(obs_vec()), 32'(exp_vec & VMASK));
        if (bus.one_sec_en === 1'b1) n_tick++;
        if (bus.add_time_n === 1'b0) begin
            n_strobe++;
            if (obs_cyc - last_strobe_cyc < 2) n_close++;
            last_strobe_cyc = obs_cyc;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int t_prev;
        reset = 1'b1;
        bus.start_game = 1'b0; bus.pause_req = 1'b0; bus.bonus_req = 1'b0;
        bus.timer_tc = 1'b0; bus.count_h = 4'd5; bus.count_m = 4'd2;
        obs_cyc = 0; last_strobe_cyc = -100; n_tick = 0; n_strobe = 0; n_close = 0;
        model_reset();
        #12;
        chk("reset_vec", 32'(obs_vec()), 32'(RST_VEC & VMASK));
        reset = 1'b0;
        step();
        chk("idle_state", 32'(bus.state), 32'd0);

        // Start: one-cycle load strobe, then RUN with a tick every T cycles.
        bus.start_game = 1'b1; step(); bus.start_game = 1'b0;
        chk("load_state", 32'(bus.state), 32'd1);
        chk("load_n_low", 32'(bus.load_n), 32'd0);
        step();
        chk("run_state", 32'(bus.state), 32'd2);
        chk("load_n_high", 32'(bus.load_n), 32'd1);
        t_prev = -1; k = 0;
        for (int i = 0; i < 26; i++) begin
            step();
            if (bus.one_sec_en === 1'b1) begin
                if (t_prev >= 0) chk("tick_period", 32'(obs_cyc - t_prev), T);
                t_prev = obs_cyc;
                k++;
            end
        end
        chk("tick_count", 32'(k), 32'd3);

        // Pause three cycles after a tick, hold, resume and measure time to next tick.
        k = 0;
        while (bus.one_sec_en !== 1'b1 && k < 20) begin step(); k++; end
        chk("tick_seen", 32'(bus.one_sec_en), 32'd1);
        step(); step(); step();
        bus.pause_req = 1'b1; step();
        chk("paused_state", 32'(bus.state), 32'd3);
        bus.pause_req = 1'b0;
        n_tick = 0;
        repeat (19) step();
        chk("paused_no_tick", 32'(n_tick), 32'd0);
        bus.pause_req = 1'b1; step(); bus.pause_req = 1'b0;
        chk("resumed_state", 32'(bus.state), 32'd2);
        k = 0;
        while (bus.one_sec_en !== 1'b1 && k < 12) begin step(); k++; end
        chk("resume_latency", 32'(k), 32'd5);

        // Four bonus edges while the middle digit is too large, then release.
        bus.count_m = 4'd7; n_strobe = 0;
        repeat (4) begin
            bus.bonus_req = 1'b1; step();
            bus.bonus_req = 1'b0; step();
        end
        chk("bonus_blocked", 32'(n_strobe), 32'd0);
        bus.count_m = 4'd2; n_strobe = 0; n_close = 0;
        repeat (24) step();
        chk("bonus_issued", 32'(n_strobe), 32'd3);
        chk("bonus_spacing", 32'(n_close), 32'd0);

        // Terminal count expires the game; nothing ticks afterwards.
        bus.timer_tc = 1'b1; step(); bus.timer_tc = 1'b0;
        chk("expired_state", 32'(bus.state), 32'd4);
        chk("expired_time_up", 32'(bus.time_up), 32'd1);
        chk("expired_run_en", 32'(bus.run_en), 32'd0);
        n_tick = 0;
        bus.pause_req = 1'b1; step(); bus.pause_req = 1'b0;
        repeat (19) step();
        chk("expired_no_tick", 32'(n_tick), 32'd0);
        chk("expired_hold", 32'(bus.state), 32'd4);

`ifdef TIMER_WARN_EN
        begin
            logic s [8];
            bus.start_game = 1'b1; step(); bus.start_game = 1'b0;
            repeat (3) step();
            bus.count_h = 4'd0; bus.count_m = 4'd0;
            step();
            for (int i = 0; i < 8; i++) begin
                s[i] = bus.low_time;
                step();
            end
            for (int i = 0; i < 8; i++) chk("low_time_blink", 32'(s[i]), 32'(((i / 2) % 2) == 0));
            bus.count_h = 4'd5; bus.count_m = 4'd2;
        end
`endif

        // Asynchronous reset in the middle of RUN.
        bus.start_game = 1'b1; step(); bus.start_game = 1'b0;
        repeat (5) step();
        bus.bonus_req = 1'b1; bus.count_m = 4'd8; step();
        bus.bonus_req = 1'b0; step();
        chk("pre_reset_run", 32'(bus.state), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_async", 32'(obs_vec()), 32'(RST_VEC & VMASK));
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_held", 32'(obs_vec()), 32'(RST_VEC & VMASK));
        reset = 1'b0;
        bus.count_m = 4'd2;
        step();

        // Random stimulus against the model.
        for (int i = 0; i < 2500; i++) begin
            bus.start_game = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) == 0) bus.pause_req = ~bus.pause_req;
            if ($urandom_range(0, 2) == 0) bus.bonus_req = ~bus.bonus_req;
            bus.timer_tc = ($urandom_range(0, 49) == 0);
            bus.count_m  = 4'($urandom_range(0, 9));
            bus.count_h  = 4'($urandom_range(0, 9));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
